cache_mem_controller: RTL and testbench

CACHE_MEM_CONTROLLER -- requirements
Module: cache_mem_controller

---
 rtl/mem_ctrl_pkg.sv | 17 +
 rtl/sat_counter.sv | 22 ++
 rtl/cache_mem_controller.sv | 121 ++++++++++++
 tb/tb_cache_mem_controller.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the cache memory controller and its helpers.
package mem_ctrl_pkg;

  localparam int ADDR_W      = 15;
  localparam int DATA_W      = 32;
  localparam int MEM_LAT_DEF = 4;
  localparam int WAIT_W      = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MISS_WAIT,
    FILL,
    RESPOND
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over a coincident increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/cache_mem_controller.sv
// Read-only cache controller: looks up the datapath, waits out main-memory latency on a
// miss, fills the line once, re-looks-up, and returns one word per CPU request.
module cache_mem_controller
  import mem_ctrl_pkg::*;
#(
  parameter int MEM_LAT = MEM_LAT_DEF,
  parameter int CNT_W   = 16
) (
  input  logic              globalclock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_ready,
  output logic              cpu_valid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_err,
  input  logic              clr_stats,
  output logic [ADDR_W-1:0] dp_addr,
  output logic              dp_wrEn,
  input  logic              dp_hit,
  input  logic [DATA_W-1:0] dp_rdata,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  state_t              state;
  logic [ADDR_W-1:0]   addr_q;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                refill;
  logic                hit_inc;
  logic                miss_inc;

  // In IDLE the datapath already sees the incoming address so the lookup can start next cycle.
  assign dp_addr = (state == IDLE) ? cpu_addr : addr_q;

  // Only the first lookup of a transaction is counted; the post-fill lookup is not.
  assign hit_inc  = (state == LOOKUP) && !refill && dp_hit;
  assign miss_inc = (state == LOOKUP) && !refill && !dp_hit;

  always_ff @(posedge globalclock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      addr_q    <= '0;
      wait_cnt  <= '0;
      refill    <= 1'b0;
      cpu_ready <= 1'b1;
      cpu_valid <= 1'b0;
      cpu_err   <= 1'b0;
      cpu_rdata <= '0;
      dp_wrEn   <= 1'b0;
    end else begin
      cpu_valid <= 1'b0;
      dp_wrEn   <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req) begin
            addr_q    <= cpu_addr;
            cpu_ready <= 1'b0;
            state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (dp_hit) begin
            cpu_rdata <= dp_rdata;
            cpu_err   <= 1'b0;
            cpu_valid <= 1'b1;
            state     <= RESPOND;
          end else if (refill) begin
            // Line still absent after a fill: report an error with a zero word.
            cpu_rdata <= '0;
            cpu_err   <= 1'b1;
            cpu_valid <= 1'b1;
            state     <= RESPOND;
          end else begin
            wait_cnt <= WAIT_W'(MEM_LAT - 1);
            state    <= MISS_WAIT;
          end
        end
        MISS_WAIT: begin
          if (wait_cnt == '0) begin
            dp_wrEn <= 1'b1;
            state   <= FILL;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        FILL: begin
          refill <= 1'b1;
          state  <= LOOKUP;
        end
        RESPOND: begin
          refill    <= 1'b0;
          cpu_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          refill    <= 1'b0;
          cpu_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_hit_cnt (
    .clk   (globalclock),
    .rst_n (reset),
    .clr   (clr_stats),
    .inc   (hit_inc),
    .count (hit_count)
  );

  sat_counter #(.W(CNT_W)) u_miss_cnt (
    .clk   (globalclock),
    .rst_n (reset),
    .clr   (clr_stats),
    .inc   (miss_inc),
    .count (miss_count)
  );

endmodule

// File: tb/tb_cache_mem_controller.sv
// Directed bench: main instance against a behavioural cache datapath, plus a 2-bit-counter
// instance that always hits, for saturation and clear-priority checks.
module tb_cache_mem_controller;
  import mem_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        cpu_req, cpu_ready, cpu_valid, cpu_err, clr_stats;
  logic [14:0] cpu_addr, dp_addr;
  logic [31:0] cpu_rdata, dp_rdata;
  logic        dp_wrEn, dp_hit;
  logic [15:0] hit_count, miss_count;

  logic        s_req, s_ready, s_valid, s_err, s_clr;
  logic [14:0] s_addr, s_dp_addr;
  logic [31:0] s_rdata, s_dp_rdata;
  logic        s_dp_wrEn, s_dp_hit;
  logic [1:0]  s_hit_count, s_miss_count;

  bit valid_mem [32768];
  bit fail_fill;
  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [31:0] word_of(input logic [14:0] a);
    return 32'hC0DE_0000 | {17'd0, a};
  endfunction

  assign dp_hit     = valid_mem[dp_addr];
  assign dp_rdata   = word_of(dp_addr);
  assign s_dp_hit   = 1'b1;
  assign s_dp_rdata = 32'h5A5A_0000 | {17'd0, s_dp_addr};

  always @(posedge clk) if (dp_wrEn && !fail_fill) valid_mem[dp_addr] <= 1'b1;

  cache_mem_controller #(.MEM_LAT(4), .CNT_W(16)) dut (
    .globalclock(clk), .reset(rst_n), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_ready(cpu_ready), .cpu_valid(cpu_valid), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .clr_stats(clr_stats), .dp_addr(dp_addr), .dp_wrEn(dp_wrEn), .dp_hit(dp_hit),
    .dp_rdata(dp_rdata), .hit_count(hit_count), .miss_count(miss_count)
  );

  cache_mem_controller #(.MEM_LAT(4), .CNT_W(2)) dut_s (
    .globalclock(clk), .reset(rst_n), .cpu_req(s_req), .cpu_addr(s_addr),
    .cpu_ready(s_ready), .cpu_valid(s_valid), .cpu_rdata(s_rdata), .cpu_err(s_err),
    .clr_stats(s_clr), .dp_addr(s_dp_addr), .dp_wrEn(s_dp_wrEn), .dp_hit(s_dp_hit),
    .dp_rdata(s_dp_rdata), .hit_count(s_hit_count), .miss_count(s_miss_count)
  );

  // Issue one request and report the cycle (T0 = accept) of cpu_valid and of dp_wrEn; -1 if absent.
  task automatic run_txn(input logic [14:0] a, output int lat, output int wr_at,
                         output logic [31:0] rd, output logic er);
    lat = -1; wr_at = -1; rd = 'x; er = 1'bx;
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = a;
    for (int t = 1; t < 40; t++) begin
      @(negedge clk);
      cpu_req = 1'b0;
      if (dp_wrEn && wr_at < 0) wr_at = t;
      if (cpu_valid) begin
        lat = t; rd = cpu_rdata; er = cpu_err;
        break;
      end
    end
    $display("txn addr=%h lat=%0d wr_at=%0d rdata=%h err=%b hits=%0d misses=%0d",
             a, lat, wr_at, rd, er, hit_count, miss_count);
  endtask

  task automatic run_sat(input bit clr_on_lookup, output int lat);
    lat = -1;
    @(negedge clk);
    s_req = 1'b1; s_addr = 15'h0042;
    for (int t = 1; t < 20; t++) begin
      @(negedge clk);
      s_req = 1'b0;
      s_clr = clr_on_lookup && (t == 1);
      if (s_valid) begin lat = t; break; end
    end
    s_clr = 1'b0;
    $display("txn sat addr=0042 lat=%0d clr=%b hits=%0d", lat, clr_on_lookup, s_hit_count);
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++; if (cpu_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", cpu_ready); end
    n_checks++; if (cpu_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", cpu_valid); end
    n_checks++; if (cpu_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", cpu_err); end
    n_checks++; if (cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0", cpu_rdata); end
    n_checks++; if (dp_wrEn !== 1'b0) begin n_fail++; $display("FAIL reset_wren got=%b exp=0", dp_wrEn); end
    n_checks++; if (hit_count !== 16'd0 || miss_count !== 16'd0) begin
      n_fail++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", hit_count, miss_count); end
    n_checks++; if (dp_addr !== 15'h1234) begin n_fail++; $display("FAIL reset_dp_addr got=%h exp=1234", dp_addr); end
    rst_n = 1'b1;
  endtask

  task automatic test_read_miss();
    int lat, wr_at; logic [31:0] rd; logic er;
    run_txn(15'h1A04, lat, wr_at, rd, er);
    n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL miss_latency got=%0d exp=8", lat); end
    n_checks++; if (wr_at !== 6) begin n_fail++; $display("FAIL miss_wren_cycle got=%0d exp=6", wr_at); end
    n_checks++; if (rd !== word_of(15'h1A04)) begin n_fail++; $display("FAIL miss_rdata got=%h exp=%h", rd, word_of(15'h1A04)); end
    n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL miss_err got=%b exp=0", er); end
    n_checks++; if (miss_count !== 16'd1 || hit_count !== 16'd0) begin
      n_fail++; $display("FAIL miss_counts got=%0d/%0d exp=0/1", hit_count, miss_count); end
  endtask

  task automatic test_read_hit();
    int lat, wr_at; logic [31:0] rd; logic er;
    run_txn(15'h0010, lat, wr_at, rd, er);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL hit_latency got=%0d exp=2", lat); end
    n_checks++; if (wr_at !== -1) begin n_fail++; $display("FAIL hit_no_fill got=%0d exp=-1", wr_at); end
    n_checks++; if (rd !== word_of(15'h0010)) begin n_fail++; $display("FAIL hit_rdata got=%h exp=%h", rd, word_of(15'h0010)); end
    n_checks++; if (hit_count !== 16'd1) begin n_fail++; $display("FAIL hit_count got=%0d exp=1", hit_count); end
    run_txn(15'h1A04, lat, wr_at, rd, er);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL refilled_hit_latency got=%0d exp=2", lat); end
    n_checks++; if (hit_count !== 16'd2 || miss_count !== 16'd1) begin
      n_fail++; $display("FAIL refilled_hit_counts got=%0d/%0d exp=2/1", hit_count, miss_count); end
  endtask

  task automatic test_busy_ignore();
    int nvalid = 0, v1 = -1, v2 = -1;
    logic [31:0] rd1 = '0, rd2 = '0;
    bit addr_ok = 1'b1;
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 15'h0200;
    for (int t = 1; t <= 24; t++) begin
      @(negedge clk);
      if (t == 1) cpu_addr = 15'h0300;
      if (t == 10) cpu_req = 1'b0;
      if (t <= 7 && dp_addr !== 15'h0200) addr_ok = 1'b0;
      if (cpu_valid) begin
        nvalid++;
        if (nvalid == 1) begin v1 = t; rd1 = cpu_rdata; end
        else begin v2 = t; rd2 = cpu_rdata; end
      end
    end
    $display("txn busy first=%0d second=%0d count=%0d", v1, v2, nvalid);
    n_checks++; if (nvalid !== 2) begin n_fail++; $display("FAIL busy_resp_count got=%0d exp=2", nvalid); end
    n_checks++; if (v1 !== 8 || v2 !== 17) begin n_fail++; $display("FAIL busy_resp_cycles got=%0d,%0d exp=8,17", v1, v2); end
    n_checks++; if (rd1 !== word_of(15'h0200)) begin n_fail++; $display("FAIL busy_latched_addr got=%h exp=%h", rd1, word_of(15'h0200)); end
    n_checks++; if (rd2 !== word_of(15'h0300)) begin n_fail++; $display("FAIL busy_second_rdata got=%h exp=%h", rd2, word_of(15'h0300)); end
    n_checks++; if (addr_ok !== 1'b1) begin n_fail++; $display("FAIL busy_dp_addr got=%b exp=1", addr_ok); end
    n_checks++; if (miss_count !== 16'd3) begin n_fail++; $display("FAIL busy_miss_count got=%0d exp=3", miss_count); end
  endtask

  task automatic test_refill_fail();
    int lat, wr_at; logic [31:0] rd; logic er;
    fail_fill = 1'b1;
    run_txn(15'h4ABC, lat, wr_at, rd, er);
    fail_fill = 1'b0;
    n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL fail_latency got=%0d exp=8", lat); end
    n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL fail_err got=%b exp=1", er); end
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL fail_rdata got=%h exp=0", rd); end
    n_checks++; if (miss_count !== 16'd4 || hit_count !== 16'd2) begin
      n_fail++; $display("FAIL fail_counts got=%0d/%0d exp=2/4", hit_count, miss_count); end
    repeat (3) @(negedge clk);
    n_checks++; if (cpu_err !== 1'b1 || cpu_rdata !== 32'h0 || cpu_valid !== 1'b0) begin
      n_fail++; $display("FAIL fail_hold got=err%b/%h/v%b exp=err1/0/v0", cpu_err, cpu_rdata, cpu_valid); end
    run_txn(15'h0010, lat, wr_at, rd, er);
    n_checks++; if (er !== 1'b0 || rd !== word_of(15'h0010)) begin
      n_fail++; $display("FAIL after_fail_hit got=err%b/%h exp=err0/%h", er, rd, word_of(15'h0010)); end
  endtask

  task automatic test_clear_stats();
    @(negedge clk); clr_stats = 1'b1;
    @(negedge clk); clr_stats = 1'b0;
    n_checks++; if (hit_count !== 16'd0 || miss_count !== 16'd0) begin
      n_fail++; $display("FAIL clear_counts got=%0d/%0d exp=0/0", hit_count, miss_count); end
  endtask

  task automatic test_mid_miss_reset();
    int nvalid = 0;
    bit seen = 1'b0;
    @(negedge clk); cpu_req = 1'b1; cpu_addr = 15'h0777;
    @(negedge clk); cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (miss_count !== 16'd1) begin n_fail++; $display("FAIL premiss_count got=%0d exp=1", miss_count); end
    rst_n = 1'b0; #1;
    n_checks++; if (cpu_ready !== 1'b1 || cpu_valid !== 1'b0 || hit_count !== 16'd0 || miss_count !== 16'd0) begin
      n_fail++; $display("FAIL midmiss_reset got=rdy%b v%b %0d/%0d exp=rdy1 v0 0/0", cpu_ready, cpu_valid, hit_count, miss_count); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); cpu_req = 1'b1; cpu_addr = 15'h0888;
    @(negedge clk); cpu_req = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      if (dp_wrEn) seen = 1'b1;
      else @(negedge clk);
    end
    n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL fill_reached got=%b exp=1", seen); end
    rst_n = 1'b0; #1;
    n_checks++; if (dp_wrEn !== 1'b0 || cpu_valid !== 1'b0) begin
      n_fail++; $display("FAIL fill_reset got=wr%b v%b exp=wr0 v0", dp_wrEn, cpu_valid); end
    @(negedge clk); rst_n = 1'b1;
    for (int t = 0; t < 15; t++) begin
      @(negedge clk);
      if (cpu_valid) nvalid++;
    end
    $display("txn aborted 0777/0888 stray_valid=%0d", nvalid);
    n_checks++; if (nvalid !== 0) begin n_fail++; $display("FAIL abort_no_valid got=%0d exp=0", nvalid); end
  endtask

  task automatic test_saturation();
    int lat;
    for (int i = 1; i <= 5; i++) begin
      run_sat(1'b0, lat);
      if (i == 2) begin
        n_checks++; if (s_hit_count !== 2'd2) begin n_fail++; $display("FAIL sat_two_hits got=%0d exp=2", s_hit_count); end
      end
    end
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL sat_hit_latency got=%0d exp=2", lat); end
    n_checks++; if (s_hit_count !== 2'd3) begin n_fail++; $display("FAIL sat_five_hits got=%0d exp=3", s_hit_count); end
    run_sat(1'b1, lat);
    n_checks++; if (s_hit_count !== 2'd0) begin n_fail++; $display("FAIL sat_clear_priority got=%0d exp=0", s_hit_count); end
    run_sat(1'b0, lat);
    n_checks++; if (s_hit_count !== 2'd1 || s_miss_count !== 2'd0) begin
      n_fail++; $display("FAIL sat_after_clear got=%0d/%0d exp=1/0", s_hit_count, s_miss_count); end
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) valid_mem[i] = 1'b0;
    valid_mem[16'h0010] = 1'b1;
    fail_fill = 1'b0;
    rst_n = 1'b0;
    cpu_req = 1'b0; cpu_addr = 15'h1234; clr_stats = 1'b0;
    s_req = 1'b0; s_addr = 15'h0; s_clr = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_read_miss();
    test_read_hit();
    test_busy_ignore();
    test_refill_fail();
    test_clear_stats();
    test_mid_miss_reset();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
